// File: rtl/ball_game_ctrl.sv
// rtl/ball_game_ctrl.sv - per-frame ball/score engine for the right-player board
//
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   x_pixel, y_pixel             : display raster counters (frame tick source)
//   is_hit_area, hit_color       : per-pixel hit evidence from overlay / colour detector
//   start                        : start / restart pulse
//   ball_in_valid/_y/_dy         : ball handed over by the left board
//   ball_out_valid/_y/_dy        : ball handed to the left board (one-cycle pulse)
//   ball_x, ball_y               : ball top-left position
//   score, game_over, is_idle    : game status for the overlay
module ball_game_ctrl #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int BALL_SIZE  = 20,
  parameter int SPEED      = 4,
  parameter int HIT_THRESH = 16,
  parameter int MAX_MISS   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       is_hit_area,
  input  logic       hit_color,
  input  logic       start,
  input  logic       ball_in_valid,
  input  logic [9:0] ball_in_y,
  input  logic [3:0] ball_in_dy,
  output logic       ball_out_valid,
  output logic [9:0] ball_out_y,
  output logic [3:0] ball_out_dy,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic       game_over,
  output logic       is_idle
);

  localparam logic [9:0]        X_CTR      = 10'((H_ACT - BALL_SIZE) / 2);
  localparam logic [9:0]        Y_CTR      = 10'((V_ACT - BALL_SIZE) / 2);
  localparam logic [9:0]        X_MAX      = 10'(H_ACT - BALL_SIZE);
  localparam logic [9:0]        Y_MAX      = 10'(V_ACT - BALL_SIZE);
  localparam logic signed [10:0] X_MAX_S   = 11'(H_ACT - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX_S   = 11'(V_ACT - BALL_SIZE);
  localparam logic signed [10:0] SPEED_S   = 11'(SPEED);
  localparam logic [7:0]        THRESH     = 8'(HIT_THRESH);
  localparam logic [7:0]        MISS_LIMIT = 8'(MAX_MISS);
  localparam logic [7:0]        SCORE_MAX  = 8'd99;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PLAY,
    S_SEND,
    S_OVER
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dx_neg_q, dx_neg_d;
  logic [3:0] dy_q, dy_d;
  logic [7:0] score_q, score_d;
  logic [7:0] miss_q, miss_d;
  logic [7:0] hit_cnt_q, hit_cnt_d;
  logic       at_end_q, at_end_d;
  logic       out_valid_q, out_valid_d;
  logic [9:0] out_y_q, out_y_d;
  logic [3:0] out_dy_q, out_dy_d;
  logic       game_over_q, game_over_d;
  logic       idle_q, idle_d;

  logic              frame_tick;
  logic              hit_frame;
  logic              dx_neg_eff;
  logic signed [10:0] x_s, y_s, dy_s, x_mv, y_mv;
  logic [9:0]        x_nx, y_nx;
  logic [3:0]        dy_nx;
  logic [7:0]        miss_inc;

  // Tick fires on the first cycle the raster sits on the last active pixel,
  // so a counter held there for several clocks still yields one tick.
  always_comb begin
    at_end_d   = (x_pixel == 10'(H_ACT - 1)) && (y_pixel == 10'(V_ACT - 1));
    frame_tick = at_end_d && !at_end_q;
    hit_frame  = (hit_cnt_q >= THRESH);

    hit_cnt_d = hit_cnt_q;
    if (frame_tick) begin
      hit_cnt_d = 8'd0;
    end else if (is_hit_area && hit_color && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end
  end

  // Candidate motion for this frame. A hit on a rightward ball reverses it
  // before the move, so the hit frame already steps left.
  always_comb begin
    dx_neg_eff = dx_neg_q || hit_frame;
    x_s  = $signed({1'b0, x_q});
    y_s  = $signed({1'b0, y_q});
    dy_s = $signed({{7{dy_q[3]}}, dy_q});
    x_mv = x_s + (dx_neg_eff ? -SPEED_S : SPEED_S);
    y_mv = y_s + dy_s;

    if (x_mv < 11'sd0) begin
      x_nx = 10'd0;
    end else if (x_mv > X_MAX_S) begin
      x_nx = X_MAX;
    end else begin
      x_nx = x_mv[9:0];
    end

    dy_nx = dy_q;
    if (y_mv < 11'sd0) begin
      y_nx  = 10'd0;
      dy_nx = ~dy_q + 4'd1;
    end else if (y_mv > Y_MAX_S) begin
      y_nx  = Y_MAX;
      dy_nx = ~dy_q + 4'd1;
    end else begin
      y_nx = y_mv[9:0];
    end

    miss_inc = miss_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_neg_d    = dx_neg_q;
    dy_d        = dy_q;
    score_d     = score_q;
    miss_d      = miss_q;
    out_valid_d = 1'b0;
    out_y_d     = out_y_q;
    out_dy_d    = out_dy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          score_d = 8'd0;
          miss_d  = 8'd0;
        end
      end

      S_WAIT: begin
        // start outranks a simultaneous handoff
        if (start) begin
          state_d = S_WAIT;
          score_d = 8'd0;
          miss_d  = 8'd0;
          x_d     = X_CTR;
          y_d     = Y_CTR;
        end else if (ball_in_valid) begin
          state_d  = S_PLAY;
          x_d      = 10'd0;
          y_d      = (ball_in_y > Y_MAX) ? Y_MAX : ball_in_y;
          dy_d     = ball_in_dy;
          dx_neg_d = 1'b0;
        end
      end

      S_PLAY: begin
        if (start) begin
          state_d = S_WAIT;
          score_d = 8'd0;
          miss_d  = 8'd0;
          x_d     = X_CTR;
          y_d     = Y_CTR;
        end else if (frame_tick) begin
          if (hit_frame && !dx_neg_q) begin
            dx_neg_d = 1'b1;
            if (score_q < SCORE_MAX) begin
              score_d = score_q + 8'd1;
            end
            x_d  = x_nx;
            y_d  = y_nx;
            dy_d = dy_nx;
          end else if (!dx_neg_q && (x_s + SPEED_S >= X_MAX_S)) begin
            miss_d  = miss_inc;
            x_d     = X_CTR;
            y_d     = Y_CTR;
            state_d = (miss_inc >= MISS_LIMIT) ? S_OVER : S_WAIT;
          end else if (dx_neg_q && (x_s < SPEED_S)) begin
            state_d     = S_SEND;
            out_valid_d = 1'b1;
            out_y_d     = y_q;
            out_dy_d    = dy_q;
          end else begin
            x_d  = x_nx;
            y_d  = y_nx;
            dy_d = dy_nx;
          end
        end
      end

      S_SEND: begin
        state_d = S_WAIT;
      end

      S_OVER: begin
        if (start) begin
          state_d = S_WAIT;
          score_d = 8'd0;
          miss_d  = 8'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    idle_d      = (state_d == S_IDLE);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= X_CTR;
      y_q         <= Y_CTR;
      dx_neg_q    <= 1'b0;
      dy_q        <= 4'd0;
      score_q     <= 8'd0;
      miss_q      <= 8'd0;
      hit_cnt_q   <= 8'd0;
      at_end_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= 10'd0;
      out_dy_q    <= 4'd0;
      game_over_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_neg_q    <= dx_neg_d;
      dy_q        <= dy_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      hit_cnt_q   <= hit_cnt_d;
      at_end_q    <= at_end_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_dy_q    <= out_dy_d;
      game_over_q <= game_over_d;
      idle_q      <= idle_d;
    end
  end

  assign ball_x         = x_q;
  assign ball_y         = y_q;
  assign score          = score_q;
  assign game_over      = game_over_q;
  assign is_idle        = idle_q;
  assign ball_out_valid = out_valid_q;
  assign ball_out_y     = out_y_q;
  assign ball_out_dy    = out_dy_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// tb/tb_ball_game_ctrl.sv - self-checking bench for ball_game_ctrl
module tb_ball_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x_pixel, y_pixel;
  logic       is_hit_area, hit_color, start;
  logic       ball_in_valid;
  logic [9:0] ball_in_y;
  logic [3:0] ball_in_dy;
  logic       ball_out_valid;
  logic [9:0] ball_out_y;
  logic [3:0] ball_out_dy;
  logic [9:0] ball_x, ball_y;
  logic [7:0] score;
  logic       game_over, is_idle;

  int checks = 0;
  int passes = 0;

  ball_game_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .is_hit_area(is_hit_area), .hit_color(hit_color),
    .start(start),
    .ball_in_valid(ball_in_valid), .ball_in_y(ball_in_y), .ball_in_dy(ball_in_dy),
    .ball_out_valid(ball_out_valid), .ball_out_y(ball_out_y), .ball_out_dy(ball_out_dy),
    .ball_x(ball_x), .ball_y(ball_y),
    .score(score), .game_over(game_over), .is_idle(is_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] in_y;
    logic [3:0] in_dy;
    int         nframes;
    int         exp_x;
    int         exp_y;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    x_pixel = 10'd639; y_pixel = 10'd479;
    cyc();
    x_pixel = 10'd0; y_pixel = 10'd0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic ball_in(input logic [9:0] y, input logic [3:0] dy);
    ball_in_valid = 1'b1; ball_in_y = y; ball_in_dy = dy;
    cyc();
    ball_in_valid = 1'b0;
  endtask

  // n qualifying pixels, then m pixels inside the box but off-colour
  task automatic hits(input int n, input int m);
    x_pixel = 10'd5; y_pixel = 10'd5;
    is_hit_area = 1'b1; hit_color = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    hit_color = 1'b0;
    for (int i = 0; i < m; i++) cyc();
    is_hit_area = 1'b0;
    x_pixel = 10'd0; y_pixel = 10'd0;
  endtask

  initial begin
    vecs[0] = '{10'd100, 4'd2,  1, 4,  102};
    vecs[1] = '{10'd100, 4'd2,  5, 20, 110};
    vecs[2] = '{10'd458, 4'd3,  1, 4,  460};
    vecs[3] = '{10'd458, 4'd3,  2, 8,  457};
    vecs[4] = '{10'd470, 4'd0,  1, 4,  460};
    vecs[5] = '{10'd2,   4'hD,  1, 4,  0};
    vecs[6] = '{10'd2,   4'hD,  2, 8,  3};

    reset_n = 1'b0;
    x_pixel = '0; y_pixel = '0;
    is_hit_area = 0; hit_color = 0; start = 0;
    ball_in_valid = 0; ball_in_y = '0; ball_in_dy = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    chk("rst_ball_x", int'(ball_x), 310);
    chk("rst_ball_y", int'(ball_y), 230);
    chk("rst_is_idle", int'(is_idle), 1);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_out_valid", int'(ball_out_valid), 0);
    chk("rst_out_y", int'(ball_out_y), 0);
    chk("rst_out_dy", int'(ball_out_dy), 0);

    frames(3);
    ball_in(10'd50, 4'd1);
    frame();
    chk("idle_ball_x", int'(ball_x), 310);
    chk("idle_ball_y", int'(ball_y), 230);
    chk("idle_is_idle", int'(is_idle), 1);

    for (int v = 0; v < 7; v++) begin
      pulse_start();
      ball_in(vecs[v].in_y, vecs[v].in_dy);
      frames(vecs[v].nframes);
      chk($sformatf("vec%0d_x", v), int'(ball_x), vecs[v].exp_x);
      chk($sformatf("vec%0d_y", v), int'(ball_y), vecs[v].exp_y);
      chk($sformatf("vec%0d_idle", v), int'(is_idle), 0);
    end

    // start and handoff together: start wins, ball stays parked
    pulse_start();
    start = 1'b1; ball_in_valid = 1'b1; ball_in_y = 10'd100; ball_in_dy = 4'd2;
    cyc();
    start = 1'b0; ball_in_valid = 1'b0;
    chk("start_wins_x", int'(ball_x), 310);
    ball_in(10'd100, 4'd2);
    chk("accept_after_x", int'(ball_x), 0);

    // handoff on the frame_tick cycle: accepted, no motion that frame
    pulse_start();
    x_pixel = 10'd639; y_pixel = 10'd479;
    ball_in_valid = 1'b1; ball_in_y = 10'd100; ball_in_dy = 4'd2;
    cyc();
    ball_in_valid = 1'b0;
    x_pixel = 10'd0; y_pixel = 10'd0;
    cyc();
    chk("tick_accept_x", int'(ball_x), 0);
    chk("tick_accept_y", int'(ball_y), 100);
    frame();
    chk("tick_next_x", int'(ball_x), 4);

    // raster held on the last pixel for several clocks: one move only
    x_pixel = 10'd639; y_pixel = 10'd479;
    repeat (5) cyc();
    x_pixel = 10'd0; y_pixel = 10'd0;
    cyc();
    chk("hold_tick_x", int'(ball_x), 8);
    chk("hold_tick_y", int'(ball_y), 104);

    // mid-frame reset discards accumulated hit pixels
    hits(10, 0);
    reset_n = 1'b0;
    cyc();
    chk("midrst_idle", int'(is_idle), 1);
    chk("midrst_x", int'(ball_x), 310);
    reset_n = 1'b1;
    cyc();
    pulse_start();
    ball_in(10'd100, 4'd0);
    hits(6, 0);
    frame();
    chk("midrst_nohit_x", int'(ball_x), 4);
    chk("midrst_nohit_score", int'(score), 0);

    // 15 qualifying pixels (plus off-colour ones) is not a hit
    pulse_start();
    ball_in(10'd100, 4'd1);
    frames(75);
    chk("pre15_x", int'(ball_x), 300);
    chk("pre15_y", int'(ball_y), 175);
    hits(15, 5);
    frame();
    chk("miss15_x", int'(ball_x), 304);
    chk("miss15_score", int'(score), 0);

    // 16 pixels is a hit; then run the ball out to the peer
    pulse_start();
    ball_in(10'd100, 4'd1);
    frames(75);
    hits(16, 0);
    frame();
    chk("hit16_score", int'(score), 1);
    chk("hit16_x", int'(ball_x), 296);
    chk("hit16_y", int'(ball_y), 176);
    frames(74);
    chk("pre_exit_x", int'(ball_x), 0);
    chk("pre_exit_y", int'(ball_y), 250);
    chk("pre_exit_valid", int'(ball_out_valid), 0);
    x_pixel = 10'd639; y_pixel = 10'd479;
    cyc();
    chk("exit_valid", int'(ball_out_valid), 1);
    chk("exit_out_y", int'(ball_out_y), 250);
    chk("exit_out_dy", int'(ball_out_dy), 1);
    chk("exit_x", int'(ball_x), 0);
    x_pixel = 10'd0; y_pixel = 10'd0;
    cyc();
    chk("exit_valid_drop", int'(ball_out_valid), 0);
    chk("exit_not_idle", int'(is_idle), 0);
    frame();
    chk("wait_x_still", int'(ball_x), 0);
    chk("wait_valid_low", int'(ball_out_valid), 0);

    // three unreturned balls end the game, score kept
    for (int b = 0; b < 3; b++) begin
      ball_in(10'd200, 4'd0);
      frames(154);
      chk($sformatf("miss%0d_pre_x", b), int'(ball_x), 616);
      frame();
      chk($sformatf("miss%0d_over", b), int'(game_over), (b == 2) ? 1 : 0);
      chk($sformatf("miss%0d_x", b), int'(ball_x), 310);
      chk($sformatf("miss%0d_score", b), int'(score), 1);
    end
    ball_in(10'd40, 4'd0);
    chk("over_ignore_x", int'(ball_x), 310);
    chk("over_hold", int'(game_over), 1);
    pulse_start();
    chk("restart_over", int'(game_over), 0);
    chk("restart_score", int'(score), 0);
    chk("restart_idle", int'(is_idle), 0);
    ball_in(10'd40, 4'd0);
    chk("restart_accept_x", int'(ball_x), 0);
    chk("restart_accept_y", int'(ball_y), 40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ball_game_ctrl.md
# ball_game_ctrl

Per-player game engine for the right-player board. It generates the ball position, score, `game_over` and `is_idle` consumed by the video overlay, and accumulates per-frame hit evidence from the overlay's hit-area flag and the paddle colour detector. It also exchanges the ball with the peer (left) board over a valid-qualified handoff. All state advances once per video frame.

## Interface
Parameters:
- `H_ACT`, 640: active pixels per line.
- `V_ACT`, 480: active lines.
- `BALL_SIZE`, 20: ball sprite edge in pixels.
- `SPEED`, 4: horizontal step per frame in pixels.
- `HIT_THRESH`, 16: minimum qualifying pixels per frame to register a hit.
- `MAX_MISS`, 3: misses that end the game.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `x_pixel`, in, 10: display horizontal counter.
- `y_pixel`, in, 10: display vertical counter.
- `is_hit_area`, in, 1: current pixel lies inside the ball box.
- `hit_color`, in, 1: current camera pixel matches the paddle colour.
- `start`, in, 1: single-cycle start/restart pulse.
- `ball_in_valid`, in, 1: peer hands the ball to this board.
- `ball_in_y`, in, 10: entry y position.
- `ball_in_dy`, in, 4: entry vertical step, signed.
- `ball_out_valid`, out, 1: single-cycle pulse; ball leaves toward the peer.
- `ball_out_y`, out, 10: exit y position.
- `ball_out_dy`, out, 4: exit vertical step, signed.
- `ball_x`, out, 10: ball top-left x.
- `ball_y`, out, 10: ball top-left y.
- `score`, out, 8: hit count, 0..99.
- `game_over`, out, 1: game ended.
- `is_idle`, out, 1: no active game.

## Operation
- **frame_tick**: single-cycle strobe. Asserted on the first `clk` where (`x_pixel`,`y_pixel`) == (`H_ACT`-1,`V_ACT`-1) and the previous cycle's pair differed, so counters held for several clocks produce one tick.
- **hit_cnt** (8-bit, saturating at 255):
  - Increments each cycle with `is_hit_area && hit_color`.
  - Cleared on frame_tick.
  - hit_this_frame = (hit_cnt >= `HIT_THRESH`) sampled at frame_tick.
- **State machine** (IDLE, WAIT_BALL, PLAY, SEND, OVER):
  - IDLE:
    - `is_idle`=1, ball parked at center.
    - `start` → WAIT_BALL.
  - WAIT_BALL:
    - On `ball_in_valid`: x=0, y=min(`ball_in_y`, `V_ACT`-`BALL_SIZE`), dy=`ball_in_dy`, dx=+`SPEED` → PLAY.
    - `ball_in_valid` is ignored in every other state.
  - PLAY, on frame_tick, in this order using pre-move position:
    1. If hit_this_frame and dx>0: dx=-`SPEED`, score+1 (saturating at 99).
    2. Else if dx>0 and x+dx >= `H_ACT`-`BALL_SIZE`: miss. miss_cnt+1; if it reaches `MAX_MISS` → OVER, else → WAIT_BALL with ball re-centered.
    3. Else if dx<0 and x < `SPEED`: → SEND.
    4. Otherwise x+=dx. Then y+=dy; if the result is <0 or >`V_ACT`-`BALL_SIZE`, clamp to the bound and negate dy.
  - SEND:
    - One cycle: `ball_out_valid`=1, `ball_out_y`=y, `ball_out_dy`=dy.
    - Then WAIT_BALL.
  - OVER:
    - `game_over`=1; ball parked at center.
    - `start` → clear score and miss_cnt → WAIT_BALL.
- `start` in WAIT_BALL or PLAY restarts: score, miss_cnt cleared → WAIT_BALL.
- Arithmetic:
  - x/y are computed in 11-bit signed, then clamped before being registered.
  - dy is sign-extended.

## Timing
- All outputs are registered.
- Reset values:
  - `ball_x` = (`H_ACT`-`BALL_SIZE`)/2 = 310, `ball_y` = (`V_ACT`-`BALL_SIZE`)/2 = 230.
  - `score`=0, `game_over`=0, `is_idle`=1, `ball_out_valid`=0, `ball_out_y`=0, `ball_out_dy`=0.
  - State=IDLE, miss_cnt=0, hit_cnt=0.
- Position/score update one `clk` after frame_tick, so the new value is stable for the entire next frame.
- `ball_out_valid` is exactly one cycle wide, one `clk` after the frame_tick that detected the exit.
- Simultaneous events:
  - Hit and right-edge miss in the same frame: the hit wins.
  - `ball_in_valid` on a frame_tick cycle in WAIT_BALL: the ball is accepted and no motion occurs that frame.
  - `start` and `ball_in_valid` in the same cycle: `start` wins.
- Reset asserted mid-frame: immediate return to reset values; hit_cnt is discarded.

## Test plan
- **Reset/idle:** hold `reset_n`=0, release → `ball_x`=310, `ball_y`=230, `is_idle`=1, `score`=0; run 3 frames with no `start` → outputs unchanged.
- **Entry and motion:** `start`, then `ball_in_valid`, `ball_in_y`=100, `ball_in_dy`=+2 → after frame 1 `ball_x`=4, `ball_y`=102; after frame 5 `ball_x`=20, `ball_y`=110.
- **Hit:** ball at x=300, assert `is_hit_area`&&`hit_color` for 16 cycles in one frame → next frame `score`=1, `ball_x`=296. Repeat with only 15 cycles → no hit, `ball_x`=304.
- **Exit to peer:** after a hit, run until x<4 → `ball_out_valid` pulses one cycle with the current y/dy; state WAIT_BALL; `ball_x` unchanged.
- **Vertical bounce:** enter with y=458, dy=+3 → next y=460, dy=-3; following frame y=457.
- **Game over and restart:** three unreturned balls reaching x>=620 → `game_over`=1 after the third miss, `score` retained; `start` → `game_over`=0, `score`=0, `ball_in_valid` accepted again.
